// File: rtl/i2c_master_wr.sv
// I2C write-only master. A start request sends START, the 7-bit address with
// R/W=0 and then up to NUM_BYTES payload bytes, checking ACK after every byte.
// The transaction closes with STOP and a one-cycle done pulse. SCL and SDA are
// modelled as open-drain: scl_o=1 releases SCL, and sda_oe=1 pulls SDA low.
module i2c_master_wr #(
    parameter int CLK_DIV   = 4,
    parameter int NUM_BYTES = 4,
    parameter int BCNT_W    = 5
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [6:0]             dev_addr,
    input  logic [8*NUM_BYTES-1:0] wdata,
    input  logic [BCNT_W-1:0]      nbytes,
    input  logic                   sda_i,
    output logic                   scl_o,
    output logic                   sda_oe,
    output logic                   busy,
    output logic                   done,
    output logic                   ack_err
);

    localparam int                TW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int                DW       = 8 * NUM_BYTES;
    localparam logic [TW-1:0]     TMR_LAST = TW'(CLK_DIV - 1);
    localparam logic [BCNT_W-1:0] NB_MAX   = BCNT_W'(NUM_BYTES);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_START    = 3'd1,
        S_ADDR     = 3'd2,
        S_ADDR_ACK = 3'd3,
        S_DATA     = 3'd4,
        S_DATA_ACK = 3'd5,
        S_STOP     = 3'd6,
        S_DONE     = 3'd7
    } state_t;

    state_t            state_r, state_s;
    logic [TW-1:0]     tmr_r, tmr_s;
    logic [1:0]        q_r, q_s;
    logic [2:0]        bit_r, bit_s;
    logic [7:0]        sh_r, sh_s;
    logic [DW-1:0]     data_r, data_s;
    logic [BCNT_W-1:0] left_r, left_s;
    logic              nack_r, nack_s;
    logic              err_s;
    logic              tick_s, bit_end_s;
    logic              scl_s, oe_s, busy_s, done_s;

    // Next-state, counter and datapath logic; bus outputs are decoded from the next state
    always_comb begin
        state_s   = state_r;
        tmr_s     = tmr_r;
        q_s       = q_r;
        bit_s     = bit_r;
        sh_s      = sh_r;
        data_s    = data_r;
        left_s    = left_r;
        nack_s    = nack_r;
        err_s     = ack_err;
        tick_s    = (tmr_r == TMR_LAST);
        bit_end_s = tick_s && (q_r == 2'd3);

        // Quarter timer runs only while the bus is being driven
        if ((state_r == S_IDLE) || (state_r == S_DONE)) begin
            tmr_s = '0;
            q_s   = 2'd0;
        end else if (tick_s) begin
            tmr_s = '0;
            q_s   = q_r + 2'd1;
        end else begin
            tmr_s = tmr_r + TW'(1);
        end

        case (state_r)
            S_IDLE: begin
                if (start) begin
                    state_s = S_START;
                    sh_s    = {dev_addr, 1'b0};
                    data_s  = wdata;
                    left_s  = (nbytes > NB_MAX) ? NB_MAX : nbytes;
                    err_s   = 1'b0;
                    bit_s   = 3'd0;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_START: begin
                if (bit_end_s) begin
                    state_s = S_ADDR;
                    bit_s   = 3'd0;
                end else begin
                    state_s = S_START;
                end
            end
            S_ADDR, S_DATA: begin
                if (bit_end_s) begin
                    sh_s  = {sh_r[6:0], 1'b0};
                    bit_s = bit_r + 3'd1;
                    if (bit_r == 3'd7) begin
                        state_s = (state_r == S_ADDR) ? S_ADDR_ACK : S_DATA_ACK;
                    end else begin
                        state_s = state_r;
                    end
                end else begin
                    state_s = state_r;
                end
            end
            S_ADDR_ACK, S_DATA_ACK: begin
                // ACK is taken at the end of the second SCL-low-to-high quarter
                if (tick_s && (q_r == 2'd2)) begin
                    nack_s = sda_i;
                end else begin
                    nack_s = nack_r;
                end
                if (bit_end_s) begin
                    if (nack_r) begin
                        err_s   = 1'b1;
                        state_s = S_STOP;
                    end else if (left_r != '0) begin
                        state_s = S_DATA;
                        sh_s    = data_r[7:0];
                        data_s  = data_r >> 8;
                        left_s  = left_r - BCNT_W'(1);
                        bit_s   = 3'd0;
                    end else begin
                        state_s = S_STOP;
                    end
                end else begin
                    state_s = state_r;
                end
            end
            S_STOP: begin
                if (bit_end_s) begin
                    state_s = S_DONE;
                end else begin
                    state_s = S_STOP;
                end
            end
            S_DONE: begin
                state_s = S_IDLE;
            end
            default: begin
                state_s = S_IDLE;
            end
        endcase

        // Output levels for the cycle that follows this edge
        scl_s  = 1'b1;
        oe_s   = 1'b0;
        busy_s = 1'b1;
        done_s = 1'b0;
        case (state_s)
            S_IDLE: begin
                busy_s = 1'b0;
            end
            S_START: begin
                oe_s = q_s[1];
            end
            S_ADDR, S_DATA: begin
                scl_s = q_s[1];
                oe_s  = ~sh_s[7];
            end
            S_ADDR_ACK, S_DATA_ACK: begin
                scl_s = q_s[1];
            end
            S_STOP: begin
                scl_s = (q_s != 2'd0);
                oe_s  = ~q_s[1];
            end
            S_DONE: begin
                done_s = 1'b1;
            end
            default: begin
                busy_s = 1'b0;
            end
        endcase
    end

    // State, counters and registered bus/status outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= S_IDLE;
            tmr_r   <= '0;
            q_r     <= 2'd0;
            bit_r   <= 3'd0;
            sh_r    <= 8'h00;
            data_r  <= '0;
            left_r  <= '0;
            nack_r  <= 1'b0;
            scl_o   <= 1'b1;
            sda_oe  <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            ack_err <= 1'b0;
        end else begin
            state_r <= state_s;
            tmr_r   <= tmr_s;
            q_r     <= q_s;
            bit_r   <= bit_s;
            sh_r    <= sh_s;
            data_r  <= data_s;
            left_r  <= left_s;
            nack_r  <= nack_s;
            scl_o   <= scl_s;
            sda_oe  <= oe_s;
            busy    <= busy_s;
            done    <= done_s;
            ack_err <= err_s;
        end
    end

endmodule

// File: tb/tb_i2c_master_wr.sv
// Directed bench for i2c_master_wr (CLK_DIV=2, NUM_BYTES=4): a vector table of
// transactions with expected latency, error flag and SDA bit stream, plus
// hand-written sequences for an ignored mid-transaction start and a
// mid-transaction reset. A bus monitor checks SCL timing and SDA stability.
module tb_i2c_master_wr;

    localparam int CD = 2;
    localparam int NB = 4;
    localparam int BW = 5;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [6:0]    dev_addr = 7'h00;
    logic [8*NB-1:0] wdata = '0;
    logic [BW-1:0] nbytes = '0;
    logic          sda_i = 1'b1;
    logic          scl_o, sda_oe, busy, done, ack_err;

    int checks = 0;
    int failures = 0;

    i2c_master_wr #(.CLK_DIV(CD), .NUM_BYTES(NB), .BCNT_W(BW)) dut (
        .clk(clk), .reset(reset), .start(start), .dev_addr(dev_addr),
        .wdata(wdata), .nbytes(nbytes), .sda_i(sda_i), .scl_o(scl_o),
        .sda_oe(sda_oe), .busy(busy), .done(done), .ack_err(ack_err)
    );

    always #5 clk = ~clk;

    // Bus monitor state
    bit mon_en = 1'b0;
    bit bits[$];
    int hi_chg = 0;
    int bad_run = 0;
    int run_len = 0;
    bit run_ok = 1'b0;
    int done_cnt = 0;
    logic prev_scl = 1'b1;
    logic prev_oe = 1'b0;

    always @(negedge clk) begin
        if (done) done_cnt <= done_cnt + 1;
        if (!mon_en) begin
            bits.delete();
            hi_chg  <= 0;
            bad_run <= 0;
            run_len <= 0;
            run_ok  <= 1'b0;
        end else begin
            if (scl_o && prev_scl && (sda_oe != prev_oe)) hi_chg <= hi_chg + 1;
            if (scl_o != prev_scl) begin
                if (run_ok) begin
                    if (prev_scl ? (run_len != 2*CD) : ((run_len != 2*CD) && (run_len != CD)))
                        bad_run <= bad_run + 1;
                end
                run_ok  <= busy;
                run_len <= 1;
                if (scl_o) bits.push_back(!sda_oe);
            end else begin
                run_len <= run_len + 1;
                if (!busy) run_ok <= 1'b0;
            end
        end
        prev_scl <= scl_o;
        prev_oe  <= sda_oe;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [6:0]  addr;
        logic [31:0] data;
        logic [4:0]  nb;
        logic        nack;
        int          exp_cyc;
        int          exp_sent;
        logic        exp_err;
    } vec_t;

    task automatic mon_clear();
        mon_en = 1'b0;
        @(negedge clk);
        @(negedge clk);
        mon_en = 1'b1;
    endtask

    task automatic run_txn(input vec_t v, input string tag, input bit glitch);
        int  k;
        int  dc0;
        bit  got;
        bit  exp_bits[$];
        int  bad_idx;
        mon_clear();
        dev_addr = v.addr;
        wdata    = v.data;
        nbytes   = v.nb;
        sda_i    = v.nack;
        dc0      = done_cnt;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk({tag, " busy_acc"}, busy, 1);
        chk({tag, " err_clear"}, ack_err, 0);
        k   = 0;
        got = 1'b0;
        while (!got && (k < 1000)) begin
            @(posedge clk);
            #1;
            k++;
            if (glitch && (k == 50)) begin
                start    = 1'b1;
                dev_addr = 7'h55;
                wdata    = 32'hFFFF_FFFF;
                nbytes   = 5'd1;
            end else begin
                start = 1'b0;
            end
            if (done) got = 1'b1;
        end
        chk({tag, " latency"}, k, v.exp_cyc);
        chk({tag, " ack_err"}, ack_err, v.exp_err);
        @(posedge clk);
        #1;
        chk({tag, " done_pulse"}, done, 0);
        chk({tag, " busy_end"}, busy, 0);
        repeat (3) @(posedge clk);
        #1;
        chk({tag, " ack_err_hold"}, ack_err, v.exp_err);
        chk({tag, " bus_idle"}, {scl_o, sda_oe}, 2'b10);
        @(negedge clk);
        chk({tag, " done_count"}, done_cnt - dc0, 1);
        chk({tag, " sda_hi_chg"}, hi_chg, 2);
        chk({tag, " scl_runs"}, bad_run, 0);
        // Expected SDA stream seen at each SCL rise: address, R/W, ACK slots released, STOP
        for (int i = 6; i >= 0; i--) exp_bits.push_back(v.addr[i]);
        exp_bits.push_back(1'b0);
        exp_bits.push_back(1'b1);
        for (int j = 0; j < v.exp_sent; j++) begin
            for (int b = 7; b >= 0; b--) exp_bits.push_back(v.data[8*j + b]);
            exp_bits.push_back(1'b1);
        end
        exp_bits.push_back(1'b0);
        bad_idx = -1;
        if (bits.size() != exp_bits.size()) begin
            bad_idx = (bits.size() < exp_bits.size()) ? bits.size() : exp_bits.size();
        end else begin
            for (int i = exp_bits.size() - 1; i >= 0; i--)
                if (bits[i] != exp_bits[i]) bad_idx = i;
        end
        checks++;
        if (bad_idx >= 0) begin
            failures++;
            $display("FAIL %s sda_bits actual_len=%0d required_len=%0d first_bad_bit=%0d",
                     tag, bits.size(), exp_bits.size(), bad_idx);
        end
    endtask

    vec_t vecs[6];

    initial begin
        int dc0;
        vecs[0] = '{7'h1A, 32'h0000_3CA5, 5'd2, 1'b0, 232, 2, 1'b0};
        vecs[1] = '{7'h1A, 32'h0000_3CA5, 5'd0, 1'b0,  88, 0, 1'b0};
        vecs[2] = '{7'h2B, 32'h1122_3344, 5'd7, 1'b0, 376, 4, 1'b0};
        vecs[3] = '{7'h1A, 32'h0000_3CA5, 5'd2, 1'b1,  88, 0, 1'b1};
        vecs[4] = '{7'h7F, 32'hDEAD_BEEF, 5'd4, 1'b0, 376, 4, 1'b0};
        vecs[5] = '{7'h00, 32'h0000_0080, 5'd1, 1'b0, 160, 1, 1'b0};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("reset scl_o", scl_o, 1);
        chk("reset sda_oe", sda_oe, 0);
        chk("reset busy", busy, 0);
        chk("reset done", done, 0);
        chk("reset ack_err", ack_err, 0);
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        for (int i = 0; i < 6; i++) run_txn(vecs[i], $sformatf("vec%0d", i), 1'b0);

        // Start pulsed mid-transaction must be ignored
        run_txn(vecs[0], "glitch", 1'b1);

        // Reset in the middle of data byte 0, bit 3
        mon_en   = 1'b0;
        dev_addr = 7'h1A;
        wdata    = 32'h0000_3CA5;
        nbytes   = 5'd2;
        sda_i    = 1'b0;
        dc0      = done_cnt;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (105) @(posedge clk);
        #1;
        chk("pre_rst busy", busy, 1);
        chk("pre_rst scl_o", scl_o, 0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("mid_rst scl_o", scl_o, 1);
        chk("mid_rst sda_oe", sda_oe, 0);
        chk("mid_rst busy", busy, 0);
        chk("mid_rst done", done, 0);
        reset = 1'b0;
        repeat (300) @(posedge clk);
        #1;
        chk("mid_rst no_done", done_cnt - dc0, 0);
        chk("mid_rst idle", {scl_o, sda_oe, busy}, 3'b100);

        run_txn(vecs[0], "after_rst", 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
